// File: rtl/svm_train_init.sv
// svm_train_init: SMO training initialiser. Reads the library header, then seeds the
// label / alpha-type / alpha / gradient RAMs once per sample. Optional: SVM_LABEL_CHECK_EN.
module svm_train_init #(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ADDR_W    = 11,
  parameter int unsigned       ROM_AW    = 16,
  parameter int unsigned       DIM_W     = 6,
  parameter int unsigned       MAX_DIM   = 63,
  parameter logic [DATA_W-1:0] POS_LABEL = 64'h1111_1111_1111_1111,
  parameter logic [DATA_W-1:0] NEG_LABEL = 64'h0000_0000_0000_0000,
  parameter logic [DATA_W-1:0] GRAD_INIT = 64'hBFF0_0000_0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              label_d,
  output logic [1:0]        type_d,
  output logic [DATA_W-1:0] alpha_d,
  output logic [DATA_W-1:0] grad_d,
  output logic [ADDR_W:0]   n_vector,
  output logic [DIM_W-1:0]  n_dim,
  output logic [ADDR_W:0]   n_pos,
  output logic [ADDR_W:0]   n_neg,
  output logic              busy,
  output logic              done,
  output logic [3:0]        err_code
);

`ifdef SVM_LABEL_CHECK_EN
  localparam bit LABEL_CHECK = 1'b1;
`else
  localparam bit LABEL_CHECK = 1'b0;
`endif

  localparam int unsigned       SUM_W  = ((ROM_AW > DIM_W) ? ROM_AW : DIM_W) + 2;
  localparam logic [DATA_W-1:0] NV_MAX = {{(DATA_W-1){1'b0}}, 1'b1} << ADDR_W;
  localparam logic [DATA_W-1:0] ND_MAX = DATA_W'(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE, S_H_NV, S_H_ND, S_CHECK, S_WALK, S_FLUSH, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     n_vector_q, n_vector_d;
  logic [DIM_W-1:0]    n_dim_q, n_dim_d;
  logic                nv_bad_q, nv_bad_d;
  logic                nd_bad_q, nd_bad_d;
  logic [ADDR_W:0]     n_pos_q, n_pos_d;
  logic [ADDR_W:0]     n_neg_q, n_neg_d;
  logic [3:0]          err_q, err_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                wlabel_q, wlabel_d;
  logic [1:0]          wtype_q, wtype_d;
  logic [DATA_W-1:0]   wgrad_q, wgrad_d;

  logic [SUM_W-1:0]    base;
  logic [SUM_W-1:0]    next_addr;
  logic                next_ovf;
  logic                idx_last;
  logic                is_pos;
  logic                bad_lbl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      ovf_q      <= 1'b0;
      idx_q      <= '0;
      n_vector_q <= '0;
      n_dim_q    <= '0;
      nv_bad_q   <= 1'b0;
      nd_bad_q   <= 1'b0;
      n_pos_q    <= '0;
      n_neg_q    <= '0;
      err_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wlabel_q   <= 1'b0;
      wtype_q    <= '0;
      wgrad_q    <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      ovf_q      <= ovf_d;
      idx_q      <= idx_d;
      n_vector_q <= n_vector_d;
      n_dim_q    <= n_dim_d;
      nv_bad_q   <= nv_bad_d;
      nd_bad_q   <= nd_bad_d;
      n_pos_q    <= n_pos_d;
      n_neg_q    <= n_neg_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wlabel_q   <= wlabel_d;
      wtype_q    <= wtype_d;
      wgrad_q    <= wgrad_d;
    end
  end

  // rom_addr runs one record ahead of rom_q, so ovf_q flags that the *next*
  // record is unreachable; the record currently on rom_q is still valid.
  always_comb begin
    base      = (state_q == S_CHECK) ? SUM_W'(2) : SUM_W'(rom_addr_q);
    next_addr = base + SUM_W'(n_dim_q) + SUM_W'(1);
    next_ovf  = |(next_addr >> ROM_AW);
    idx_last  = ({1'b0, idx_q} == (n_vector_q - (ADDR_W+1)'(1)));
    is_pos    = (rom_q == POS_LABEL);
    bad_lbl   = LABEL_CHECK && (rom_q != POS_LABEL) && (rom_q != NEG_LABEL);
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    ovf_d      = ovf_q;
    idx_d      = idx_q;
    n_vector_d = n_vector_q;
    n_dim_d    = n_dim_q;
    nv_bad_d   = nv_bad_q;
    nd_bad_d   = nd_bad_q;
    n_pos_d    = n_pos_q;
    n_neg_d    = n_neg_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wlabel_d   = wlabel_q;
    wtype_d    = wtype_q;
    wgrad_d    = wgrad_q;
    case (state_q)
      S_IDLE: begin
        rom_addr_d = '0;
        if (start) begin
          state_d    = S_H_NV;
          rom_addr_d = ROM_AW'(1);
          n_pos_d    = '0;
          n_neg_d    = '0;
          err_d      = '0;
        end
      end
      S_H_NV: begin
        n_vector_d = rom_q[ADDR_W:0];
        nv_bad_d   = (rom_q == '0) || (rom_q > NV_MAX);
        rom_addr_d = ROM_AW'(2);
        state_d    = S_H_ND;
      end
      S_H_ND: begin
        n_dim_d  = rom_q[DIM_W-1:0];
        nd_bad_d = (rom_q == '0) || (rom_q > ND_MAX);
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (nv_bad_q || nd_bad_q) begin
          err_d[0] = nv_bad_q;
          err_d[1] = nd_bad_q;
          state_d  = S_DONE;
        end else begin
          rom_addr_d = next_addr[ROM_AW-1:0];
          ovf_d      = next_ovf;
          idx_d      = '0;
          state_d    = S_WALK;
        end
      end
      S_WALK: begin
        if (bad_lbl) begin
          err_d[3] = 1'b1;
          state_d  = S_FLUSH;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = idx_q;
          wlabel_d   = is_pos;
          wtype_d    = is_pos ? 2'b10 : 2'b01;
          wgrad_d    = GRAD_INIT;
          if (is_pos) n_pos_d = n_pos_q + (ADDR_W+1)'(1);
          else        n_neg_d = n_neg_q + (ADDR_W+1)'(1);
          idx_d      = idx_q + ADDR_W'(1);
          rom_addr_d = next_addr[ROM_AW-1:0];
          ovf_d      = next_ovf;
          if (idx_last) begin
            state_d = S_FLUSH;
          end else if (ovf_q) begin
            err_d[2] = 1'b1;
            state_d  = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        rom_addr_d = '0;
        ovf_d      = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr = rom_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign label_d  = wlabel_q;
  assign type_d   = wtype_q;
  assign alpha_d  = '0;
  assign grad_d   = wgrad_q;
  assign n_vector = n_vector_q;
  assign n_dim    = n_dim_q;
  assign n_pos    = n_pos_q;
  assign n_neg    = n_neg_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err_code = err_q;

endmodule

// File: tb/tb_svm_train_init.sv
// Bench for svm_train_init: behavioural model of the ROM walk, per-cycle compare,
// randomized jobs plus directed header/boundary/reset cases; small-ROM instance for overflow.
module tb_svm_train_init;

`ifdef SVM_LABEL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam logic [63:0] POS  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] NEG  = 64'h0;
  localparam logic [63:0] GRAD = 64'hBFF0_0000_0000_0000;

  logic        clk, rst, start;
  logic [15:0] rom_addr;
  logic [63:0] rom_q;
  logic        wr_en, label_d, busy, done;
  logic [10:0] wr_addr;
  logic [1:0]  type_d;
  logic [63:0] alpha_d, grad_d;
  logic [11:0] n_vector, n_pos, n_neg;
  logic [5:0]  n_dim;
  logic [3:0]  err_code;

  logic        s_start;
  logic [5:0]  s_rom_addr;
  logic [63:0] s_rom_q;
  logic        s_wr_en, s_label_d, s_busy, s_done;
  logic [10:0] s_wr_addr;
  logic [1:0]  s_type_d;
  logic [63:0] s_alpha_d, s_grad_d;
  logic [11:0] s_n_vector, s_n_pos, s_n_neg;
  logic [5:0]  s_n_dim;
  logic [3:0]  s_err_code;

  logic [63:0] rom   [0:65535];
  logic [63:0] rom_s [0:63];

  svm_train_init dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_q(rom_q),
    .wr_en(wr_en), .wr_addr(wr_addr), .label_d(label_d), .type_d(type_d),
    .alpha_d(alpha_d), .grad_d(grad_d), .n_vector(n_vector), .n_dim(n_dim),
    .n_pos(n_pos), .n_neg(n_neg), .busy(busy), .done(done), .err_code(err_code)
  );

  svm_train_init #(.ROM_AW(6)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .rom_addr(s_rom_addr), .rom_q(s_rom_q),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .label_d(s_label_d), .type_d(s_type_d),
    .alpha_d(s_alpha_d), .grad_d(s_grad_d), .n_vector(s_n_vector), .n_dim(s_n_dim),
    .n_pos(s_n_pos), .n_neg(s_n_neg), .busy(s_busy), .done(s_done), .err_code(s_err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    rom_q   <= rom[rom_addr];
    s_rom_q <= rom_s[s_rom_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // model results
  bit          exp_lbl [0:2047];
  int          nw, exp_done, exp_pos, exp_neg;
  logic [3:0]  exp_err;
  logic [11:0] exp_nv;
  logic [5:0]  exp_nd;
  int          rel;
  bit          job_on;
  bit          wexp;

  task automatic model();
    longint unsigned nv, nd, a;
    int last;
    nv = rom[0]; nd = rom[1];
    exp_nv = rom[0][11:0]; exp_nd = rom[1][5:0];
    exp_err = '0; nw = 0; exp_pos = 0; exp_neg = 0;
    if (nv < 1 || nv > 2048) exp_err[0] = 1'b1;
    if (nd < 1 || nd > 63)   exp_err[1] = 1'b1;
    if (exp_err != 0) begin
      exp_done = 4;
      return;
    end
    last = int'(nv) - 1;
    for (int k = 0; k < int'(nv); k++) begin
      a = 64'd2 + 64'(k) * (nd + 64'd1);
      if (a >= 64'd65536) begin exp_err[2] = 1'b1; last = k - 1; break; end
      if (CHK_EN && rom[int'(a)] != POS && rom[int'(a)] != NEG) begin
        exp_err[3] = 1'b1; last = k; break;
      end
      exp_lbl[nw] = (rom[int'(a)] == POS);
      if (exp_lbl[nw]) exp_pos++; else exp_neg++;
      nw++;
    end
    exp_done = 6 + last;
  endtask

  task automatic gen(input longint unsigned nv, input longint unsigned nd, input int bad_pct);
    longint unsigned a;
    rom[0] = nv; rom[1] = nd;
    if (nv >= 1 && nv <= 2048 && nd >= 1 && nd <= 63)
      for (longint unsigned k = 0; k < nv; k++) begin
        a = 64'd2 + k * (nd + 64'd1);
        if (a < 64'd65536) begin
          if (int'($urandom_range(99, 0)) < bad_pct) rom[int'(a)] = {$urandom, $urandom} | 64'h2;
          else rom[int'(a)] = $urandom_range(1, 0) ? POS : NEG;
        end
      end
  endtask

  task automatic run_job(input bit busy_start);
    model();
    @(posedge clk); #1;
    rel = -1; job_on = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < exp_done + 20 && job_on; i++) @(posedge clk);
    #1;
    if (job_on) begin
      chk("job_timeout", 64'(rel), 64'(exp_done + 1));
      job_on = 1'b0;
    end
  endtask

  // single compare process: outputs vs model on every cycle
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_a", {rom_addr, wr_en, wr_addr, label_d, type_d, n_dim, err_code, done, busy}, 64'd0);
      chk("rst_b", {n_vector, n_pos, n_neg}, 64'd0);
      chk("rst_alpha", alpha_d, 64'd0);
      chk("rst_grad", grad_d, 64'd0);
    end else if (job_on) begin
      rel++;
      if (rel >= 1) begin
        wexp = (rel >= 5) && (rel - 5 < nw);
        chk("wr_en", wr_en, wexp);
        if (wexp) begin
          chk("wr_addr", wr_addr, 64'(rel - 5));
          chk("label", label_d, exp_lbl[rel-5]);
          chk("type", type_d, exp_lbl[rel-5] ? 64'd2 : 64'd1);
          chk("alpha", alpha_d, 64'd0);
          chk("grad", grad_d, GRAD);
        end
        chk("done", done, rel == exp_done);
        chk("busy", busy, rel <= exp_done);
        if (rel == exp_done) begin
          chk("err_code", err_code, exp_err);
          chk("n_pos", n_pos, 64'(exp_pos));
          chk("n_neg", n_neg, 64'(exp_neg));
          chk("n_vector", n_vector, exp_nv);
          chk("n_dim", n_dim, exp_nd);
        end
        if (rel > exp_done) job_on = 1'b0;
      end
    end else begin
      chk("idle_wr_en", wr_en, 64'd0);
      chk("idle_busy", busy, 64'd0);
      chk("idle_done", done, 64'd0);
    end
  end

  task automatic load_t1();
    rom[0] = 64'd3; rom[1] = 64'd2;
    rom[2] = POS; rom[5] = NEG; rom[8] = POS;
  endtask

  initial begin
    int s_writes, s_done_at;
    for (int i = 0; i < 65536; i++) rom[i] = {$urandom, $urandom};
    for (int i = 0; i < 64; i++) rom_s[i] = 64'd0;
    rst = 1'b1; start = 1'b0; s_start = 1'b0; job_on = 1'b0; rel = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // T1 with model pinned to hand values
    load_t1();
    model();
    chk("T1_model_done", 64'(exp_done), 64'd8);
    chk("T1_model_nw", 64'(nw), 64'd3);
    chk("T1_model_pos", 64'(exp_pos), 64'd2);
    run_job(1'b0);
    chk("T1_n_pos", n_pos, 64'd2);
    chk("T1_n_neg", n_neg, 64'd1);
    chk("T1_err", err_code, 64'd0);

    // T2: bad n_vector, including a 64-bit value whose low bits look legal
    gen(64'd0, 64'd2, 0);
    model();
    chk("T2_model_done", 64'(exp_done), 64'd4);
    chk("T2_model_err", exp_err, 64'd1);
    run_job(1'b0);
    gen(64'd2049, 64'd2, 0);         run_job(1'b0);
    gen(64'h1_0000_0003, 64'd2, 0);  run_job(1'b0);

    // T3: n_dim boundaries
    gen(64'd4, 64'd64, 0);           run_job(1'b0);
    chk("T3_err", err_code, 64'd2);
    gen(64'd4, 64'd0, 0);            run_job(1'b0);
    gen(64'd0, 64'd64, 0);           run_job(1'b0);
    gen(64'd1, 64'd63, 0);           run_job(1'b0);
    chk("T3_ok_err", err_code, 64'd0);

    // T4: unknown label word on record 1
    load_t1();
    rom[5] = 64'h5;
    run_job(1'b0);

    // n_vector / ROM-range boundaries
    gen(64'd2048, 64'd1, 0);         run_job(1'b0);
    gen(64'd1024, 64'd63, 0);        run_job(1'b0);
    gen(64'd2048, 64'd63, 0);        run_job(1'b0);
    chk("ovf_err", err_code, 64'd4);

    // randomized jobs
    for (int j = 0; j < 24; j++) begin
      if (j % 6 == 5)
        gen(64'($urandom_range(2, 0) * 2049), 64'($urandom_range(64, 0)), 0);
      else
        gen(64'($urandom_range(40, 1)), 64'($urandom_range(63, 1)), (j % 3 == 0) ? 10 : 0);
      run_job(j[0]);
    end

    // T6: reset in WALK, then a fresh job with a start while busy
    gen(64'd30, 64'd3, 0);
    model();
    @(posedge clk); #1;
    rel = -1; job_on = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1; job_on = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    load_t1();
    run_job(1'b1);
    chk("T6_n_pos", n_pos, 64'd2);
    chk("T6_n_neg", n_neg, 64'd1);

    // T5: 64-word ROM, record 3 would sit past the end
    rom_s[0] = 64'd4; rom_s[1] = 64'd20;
    rom_s[2] = POS; rom_s[23] = NEG; rom_s[44] = POS;
    s_writes = 0; s_done_at = 0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (s_wr_en) begin
        chk("T5_wr_addr", s_wr_addr, 64'(s_writes));
        chk("T5_label", s_label_d, (s_writes == 1) ? 64'd0 : 64'd1);
        s_writes++;
      end
      if (s_done) begin
        s_done_at = j;
        chk("T5_err", s_err_code, 64'd4);
        chk("T5_n_pos", s_n_pos, 64'd2);
        chk("T5_n_neg", s_n_neg, 64'd1);
      end
    end
    chk("T5_writes", 64'(s_writes), 64'd3);
    chk("T5_done_at", 64'(s_done_at), 64'd8);
    chk("T5_busy_end", s_busy, 64'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
